// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit (radix-2, one result bit per clock)
//
// Purpose: executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU on register-file
// operands and presents write-back data, destination and write enable.
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous active-low reset
//   start        request, sampled only while idle
//   funct3       operation select
//   operand_a    rs1 value
//   operand_b    rs2 value
//   dest_reg     rd index
//   busy         high while an operation is in flight (CALC or DONE)
//   done         one-cycle completion pulse
//   result       write-back data, held until the next done
//   result_reg   rd of the completed operation, held until the next done
//   regwrite_out done qualified by a non-zero destination
module muldiv_unit #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 6
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [2:0]            funct3,
    input  logic [XLEN-1:0]       operand_a,
    input  logic [XLEN-1:0]       operand_b,
    input  logic [REG_ADDR_W-1:0] dest_reg,
    output logic                  busy,
    output logic                  done,
    output logic [XLEN-1:0]       result,
    output logic [REG_ADDR_W-1:0] result_reg,
    output logic                  regwrite_out
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t                r_state;
    state_t                w_next_state;

    logic [2:0]            r_op;
    logic [REG_ADDR_W-1:0] r_rd;
    logic [CNT_W-1:0]      r_cnt;
    logic [XLEN-1:0]       r_acc;     // product high half / partial remainder
    logic [XLEN-1:0]       r_lo;      // multiplier -> product low half / dividend -> quotient
    logic [XLEN-1:0]       r_opnd;    // multiplicand / divisor magnitude
    logic                  r_neg;     // final result must be negated
    logic [XLEN-1:0]       r_result;
    logic [REG_ADDR_W-1:0] r_result_reg;

    // ---------------- operand decode at issue ----------------
    logic            w_is_div;
    logic            w_a_signed;
    logic            w_b_signed;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic            w_neg_start;
    logic            w_div_zero;
    logic            w_div_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_special_val;

    assign w_is_div   = funct3[2];
    // MULH, MULHSU, DIV, REM treat rs1 as signed; MULH, DIV, REM treat rs2 as signed.
    // MUL is run unsigned: the low half of the product does not depend on signedness.
    assign w_a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3[2] && !funct3[0]);
    assign w_b_signed = (funct3 == 3'b001) || (funct3[2] && !funct3[0]);
    assign w_a_neg    = w_a_signed && operand_a[XLEN-1];
    assign w_b_neg    = w_b_signed && operand_b[XLEN-1];
    assign w_a_mag    = w_a_neg ? (~operand_a + 1'b1) : operand_a;
    assign w_b_mag    = w_b_neg ? (~operand_b + 1'b1) : operand_b;
    // Remainder takes the dividend's sign; product and quotient take the xor.
    assign w_neg_start = (w_is_div && funct3[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);

    assign w_div_zero = w_is_div && (operand_b == '0);
    assign w_div_ovf  = w_is_div && !funct3[0]
                        && (operand_a == {1'b1, {(XLEN-1){1'b0}}})
                        && (operand_b == {XLEN{1'b1}});
    assign w_special  = w_div_zero || w_div_ovf;
    assign w_special_val = w_div_zero ? (funct3[1] ? operand_a : {XLEN{1'b1}})
                                      : (funct3[1] ? '0 : operand_a);

    // ---------------- one iteration step ----------------
    logic [XLEN:0]     w_msum;
    logic [XLEN-1:0]   w_mul_acc;
    logic [XLEN-1:0]   w_mul_lo;
    logic [XLEN:0]     w_dshift;
    logic [XLEN:0]     w_ddiff;
    logic [XLEN-1:0]   w_div_acc;
    logic [XLEN-1:0]   w_div_lo;
    logic [XLEN-1:0]   w_step_acc;
    logic [XLEN-1:0]   w_step_lo;

    // Shift-add: the carry out of the high-half add shifts into the top bit.
    assign w_msum    = {1'b0, r_acc} + (r_lo[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_acc = w_msum[XLEN:1];
    assign w_mul_lo  = {w_msum[0], r_lo[XLEN-1:1]};

    // Restoring divide: a borrow (bit XLEN set) means keep the shifted remainder.
    assign w_dshift  = {r_acc, r_lo[XLEN-1]};
    assign w_ddiff   = w_dshift - {1'b0, r_opnd};
    assign w_div_acc = w_ddiff[XLEN] ? w_dshift[XLEN-1:0] : w_ddiff[XLEN-1:0];
    assign w_div_lo  = {r_lo[XLEN-2:0], ~w_ddiff[XLEN]};

    assign w_step_acc = r_op[2] ? w_div_acc : w_mul_acc;
    assign w_step_lo  = r_op[2] ? w_div_lo  : w_mul_lo;

    // ---------------- sign correction of the final step ----------------
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_quo_fix;
    logic [XLEN-1:0]   w_rem_fix;
    logic [XLEN-1:0]   w_final;
    logic              w_last;

    assign w_prod     = {w_mul_acc, w_mul_lo};
    assign w_prod_fix = r_neg ? (~w_prod + 1'b1) : w_prod;
    assign w_quo_fix  = r_neg ? (~w_div_lo + 1'b1) : w_div_lo;
    assign w_rem_fix  = r_neg ? (~w_div_acc + 1'b1) : w_div_acc;
    assign w_final    = r_op[2] ? (r_op[1] ? w_rem_fix : w_quo_fix)
                                : ((r_op[1:0] == 2'b00) ? w_prod_fix[XLEN-1:0]
                                                        : w_prod_fix[2*XLEN-1:XLEN]);
    assign w_last     = (r_cnt == CNT_W'(XLEN-1));

    // ---------------- FSM ----------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (start) w_next_state = w_special ? S_DONE : S_CALC;
            S_CALC: if (w_last) w_next_state = S_DONE;
            S_DONE: w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_op         <= '0;
            r_rd         <= '0;
            r_cnt        <= '0;
            r_acc        <= '0;
            r_lo         <= '0;
            r_opnd       <= '0;
            r_neg        <= 1'b0;
            r_result     <= '0;
            r_result_reg <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op   <= funct3;
                        r_rd   <= dest_reg;
                        r_cnt  <= '0;
                        r_acc  <= '0;
                        r_neg  <= w_neg_start;
                        r_lo   <= w_is_div ? w_a_mag : w_b_mag;
                        r_opnd <= w_is_div ? w_b_mag : w_a_mag;
                        if (w_special) begin
                            r_result     <= w_special_val;
                            r_result_reg <= dest_reg;
                        end
                    end
                end
                S_CALC: begin
                    r_acc <= w_step_acc;
                    r_lo  <= w_step_lo;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_result     <= w_final;
                        r_result_reg <= r_rd;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy         = (r_state != S_IDLE);
    assign done         = (r_state == S_DONE);
    assign result       = r_result;
    assign result_reg   = r_result_reg;
    assign regwrite_out = done && (r_result_reg != '0);

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit. It sits directly downstream of the register file.
- It consumes read_data1 and read_data2 as operands and produces the write-back data, destination and write enable for the register file's write port.
- A start/busy/done handshake lets control stall the single-cycle datapath while an M-extension instruction completes.
- It uses radix-2 iteration: one result bit per clock.

Parameters:
- XLEN, 32, operand/result width in bits.
- REG_ADDR_W, 5, register index width.
- CNT_W, 6, iteration counter width; must hold XLEN.

Ports:
- clock  input  1  single rising-edge clock.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- start  input  1  request; sampled only in IDLE.
- funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- operand_a  input  XLEN  rs1 value (read_data1).
- operand_b  input  XLEN  rs2 value (read_data2).
- dest_reg  input  REG_ADDR_W  rd index.
- busy  output  1  high whenever the state is not IDLE.
- done  output  1  one-cycle pulse; result is valid.
- result  output  XLEN  write-back data; holds its value until the next done.
- result_reg  output  REG_ADDR_W  captured rd; holds its value until the next done.
- regwrite_out  output  1  equals done AND (result_reg != 0).

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - busy=0, done=0, regwrite_out=0, result=0, result_reg=0.
  - Counter and all internal operand/accumulator registers are cleared.
- States: IDLE, CALC, DONE.
- IDLE:
  - If start=1 at rising edge N, capture funct3, dest_reg, the operands' magnitudes and the sign-fix flags, and clear the counter.
  - Special divide cases go to DONE at edge N. The result register is loaded at edge N.
  - All other operations go to CALC.
- CALC:
  - One shift-add (multiply) or shift-subtract restoring step (divide) per cycle.
  - The counter increments each cycle. After XLEN iterations (edge N+XLEN) the sign-corrected result is loaded and the state goes to DONE.
- DONE:
  - done=1 for exactly one cycle, then the state returns to IDLE at the next edge.
- Latency:
  - Normal operations: done is high in the cycle after edge N+32, i.e. 33 cycles from start.
  - Special cases: done is high in the cycle after edge N, i.e. 1 cycle from start.
- Arithmetic (bit-exact per RV32M):
  - MUL returns the low XLEN bits of the product.
  - MULH returns the high XLEN bits, signed×signed.
  - MULHSU returns the high XLEN bits, signed a × unsigned b.
  - MULHU returns the high XLEN bits, unsigned×unsigned.
  - Signed operations iterate on magnitudes. The 2·XLEN product, or the quotient/remainder, is negated at the end as required.
  - Remainder sign follows the dividend.
  - Division truncates toward zero.
- Special cases (1-cycle path):
  - Divide by zero: DIV/DIVU return 0xFFFFFFFF; REM/REMU return the dividend.
  - Signed overflow, 0x80000000 / 0xFFFFFFFF: DIV returns 0x80000000; REM returns 0.
- Handshake:
  - start while busy=1 (CALC or DONE) is ignored. No queuing, and captured operands are not disturbed.
  - start is accepted on the edge after DONE (back-to-back issue possible, with IDLE lasting one cycle minimum).
  - Operand inputs may change freely after the accepting edge.
- dest_reg=0: the operation runs normally and done pulses, but regwrite_out stays 0.
- Reset mid-operation: the state is abandoned immediately, no done pulse is produced, and all outputs return to their reset values.
- After reset deasserts, the first edge is able to accept start.

Test Plan:
- Reset held low, then released; start MUL, a=7, b=0xFFFFFFFD, rd=5 -> busy goes high next cycle; done pulses exactly 33 cycles after the start edge with result=0xFFFFFFEB, result_reg=5, regwrite_out=1.
- High-half multiplies:
  - MULH 0x80000000×0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0x00000002 -> 0xFFFFFFFF.
- Signed division, -7 by 2:
  - DIV a=0xFFFFFFF9, b=2 -> 0xFFFFFFFD.
  - REM same operands -> 0xFFFFFFFF.
  - DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Special cases, each with done one cycle after start:
  - DIV 5/0 -> 0xFFFFFFFF.
  - REMU 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM of the same operands -> 0.
- Handshake:
  - Second start with different operands at cycle 10 of a DIVU -> ignored; original result is still produced at cycle 33.
  - rd=0 -> done=1, regwrite_out=0.
  - Back-to-back starts -> the second start is accepted on the edge after DONE.
- Reset pulled low asynchronously at cycle 10 of a MUL, between clock edges -> busy, done and result drop to 0 immediately; no done pulse follows; a new MUL after release completes correctly.
